// File: rtl/param_multicycle_cpu.sv
// param_multicycle_cpu -- parametrised multi-cycle ALU/branch core.
//
// Each instruction walks FETCH -> DECODE -> EXEC -> WB, which is four clocks.
// HLT leaves EXEC for HALT and does not retire. The instruction memory is
// loaded through the imem_* port. The register file is observed through the
// dbg_* port.
//
// Optional feature macro: ALU_SAT_EN. When it is defined, ADD and SUB are
// unsigned saturating. Otherwise they wrap modulo 2**DATA_W.
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   start               run from PC=0 (honoured in IDLE/HALT only)
//   imem_we/waddr/wdata instruction write port (honoured in IDLE/HALT only)
//   dbg_raddr/dbg_rdata combinational register read
//   pc, busy, halted    current PC and run status
//   err                 sticky illegal-opcode flag
//   retired             retired-instruction count (wraps)
module param_multicycle_cpu #(
    parameter  int DATA_W     = 8,
    parameter  int RAW        = 4,
    parameter  int IMEM_DEPTH = 16,
    parameter  int CNT_W      = 16,
    localparam int PC_W       = $clog2(IMEM_DEPTH),
    localparam int INSTR_W    = 4 + 3*RAW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               imem_we,
    input  logic [PC_W-1:0]    imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    input  logic [RAW-1:0]     dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [CNT_W-1:0]   retired
);
    localparam int NREG = 2**RAW;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t              state;
    logic [INSTR_W-1:0]  imem [IMEM_DEPTH];
    logic [DATA_W-1:0]   regs [NREG];
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   op_a, op_b, op_d;

    // EXEC results held for WB
    logic [DATA_W-1:0]   res_q;
    logic                wr_q, ill_q;
    logic [PC_W-1:0]     npc_q;

    logic                loadable;
    logic [3:0]          opc;
    logic [RAW-1:0]      rd, rs, rt;
    logic [2*RAW-1:0]    imm;
    logic [DATA_W-1:0]   imm_data;
    logic [PC_W-1:0]     imm_pc;
    logic [DATA_W-1:0]   result;
    logic                wr_en, illegal;
    logic [PC_W-1:0]     next_pc;

    assign loadable  = (state == S_IDLE) || (state == S_HALT);
    assign opc       = ir[INSTR_W-1 -: 4];
    assign rd        = ir[3*RAW-1 -: RAW];
    assign rs        = ir[2*RAW-1 -: RAW];
    assign rt        = ir[RAW-1:0];
    assign imm       = ir[2*RAW-1:0];
    assign imm_pc    = imm[PC_W-1:0];
    assign dbg_rdata = regs[dbg_raddr];

    // LDI immediate is zero-extended or truncated to the register width
    generate
        if (DATA_W >= 2*RAW) begin : g_imm_ext
            assign imm_data = DATA_W'(imm);
        end else begin : g_imm_trunc
            assign imm_data = imm[DATA_W-1:0];
        end
    endgenerate

`ifdef ALU_SAT_EN
    logic [DATA_W:0] sum, diff;
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};   // MSB set means borrow
`endif

    always_comb begin
        result  = '0;
        wr_en   = 1'b0;
        illegal = 1'b0;
        next_pc = pc + PC_W'(1);
        case (opc)
            4'd0: ;
`ifdef ALU_SAT_EN
            4'd1: begin result = sum[DATA_W]  ? '1 : sum[DATA_W-1:0];  wr_en = 1'b1; end
            4'd2: begin result = diff[DATA_W] ? '0 : diff[DATA_W-1:0]; wr_en = 1'b1; end
`else
            4'd1: begin result = op_a + op_b; wr_en = 1'b1; end
            4'd2: begin result = op_a - op_b; wr_en = 1'b1; end
`endif
            4'd3: begin result = op_a & op_b; wr_en = 1'b1; end
            4'd4: begin result = op_a | op_b; wr_en = 1'b1; end
            4'd5: begin result = op_a ^ op_b; wr_en = 1'b1; end
            4'd6: begin result = imm_data;    wr_en = 1'b1; end
            4'd7: if (op_d == '0) next_pc = imm_pc;
            4'd8: next_pc = imm_pc;
            4'd15: ;
            default: illegal = 1'b1;
        endcase
    end

    // Instruction memory is not reset. A write commits in the same cycle as
    // start, so the first FETCH already sees the new word.
    always_ff @(posedge clk) begin
        if (imem_we && loadable)
            imem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            err     <= 1'b0;
            retired <= '0;
            ir      <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_d    <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            npc_q   <= '0;
            for (int k = 0; k < NREG; k++)
                regs[k] <= DATA_W'(k);
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= imem[pc];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    op_a  <= regs[rs];
                    op_b  <= regs[rt];
                    op_d  <= regs[rd];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (opc == 4'd15) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        res_q <= result;
                        wr_q  <= wr_en;
                        ill_q <= illegal;
                        npc_q <= next_pc;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (wr_q)
                        regs[rd] <= res_q;
                    if (ill_q)
                        err <= 1'b1;
                    pc      <= npc_q;
                    retired <= retired + CNT_W'(1);
                    state   <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
